// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding, the
// maximum loadable duration and a helper that clamps a requested duration.
// No ports; imported by countdown_timer.
package countdown_timer_pkg;

    localparam logic [6:0] MAX_TICKS = 7'd100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_e;

    // Durations above MAX_TICKS saturate rather than being rejected.
    function automatic logic [6:0] clamp_ticks(input logic [6:0] v);
        return (v > MAX_TICKS) ? MAX_TICKS : v;
    endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler producing one-cycle tick pulses at TICK_HZ from a CLK_HZ clock.
// Ports: clk, reset (sync, active-high), run (advance), clear (force to 0),
//        tick (high for the cycle the count sits at DIV-1 while running).
module tick_gen #(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV  = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Gated by run so a count frozen at LAST while paused does not fire.
    assign tick = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer: load a duration in ticks, start/pause/resume, pulse on expiry.
// Ports: clk, reset (sync, active-high), load/load_val, start, pause strobes;
//        remaining (ticks left), busy (RUN or PAUSED), expired (one-cycle pulse).
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 100_000_000,
    parameter int unsigned TICK_HZ = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic [6:0] remaining,
    output logic       busy,
    output logic       expired
);

    state_e     state_q, state_d;
    logic [6:0] rem_q, rem_d;
    logic       exp_q, exp_d;
    logic       tick;
    logic       pre_run;
    logic       pre_clear;

    // Prescaler holds in PAUSED so a resumed countdown keeps its partial tick.
    assign pre_run   = (state_q == ST_RUN);
    assign pre_clear = load || !((state_q == ST_RUN) || (state_q == ST_PAUSED));

    tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .run  (pre_run),
        .clear(pre_clear),
        .tick (tick)
    );

    // Strobe priority: load, then start, then pause.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        exp_d   = 1'b0;
        if (load) begin
            state_d = ST_ARMED;
            rem_d   = clamp_ticks(load_val);
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (start) begin
                        if (rem_q == 7'd0) begin
                            // Zero duration expires immediately, never running.
                            state_d = ST_EXPIRED;
                            exp_d   = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick && (rem_q != 7'd0)) begin
                        rem_d = rem_q - 7'd1;
                        if (rem_q == 7'd1) begin
                            // Final tick wins over a coincident pause.
                            state_d = ST_EXPIRED;
                            exp_d   = 1'b1;
                        end else if (pause) begin
                            state_d = ST_PAUSED;
                        end
                    end else if (pause) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // IDLE and EXPIRED wait for load or reset.
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rem_q   <= 7'd0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            exp_q   <= exp_d;
        end
    end

    assign remaining = rem_q;
    assign expired   = exp_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSED);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 10, countdown tick rate in Hz (0.1 s step).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 load  input  1  single-cycle strobe; captures load_val as the new duration.
REQ-006 load_val  input  7  duration in ticks, unsigned, legal range 0..100.
REQ-007 start  input  1  single-cycle strobe; begins or resumes countdown.
REQ-008 pause  input  1  single-cycle strobe; freezes countdown.
REQ-009 remaining  output  7  ticks left, registered.
REQ-010 busy  output  1  high while state is RUN or PAUSED.
REQ-011 expired  output  1  one-cycle registered pulse at countdown completion.

Function
REQ-012 Prescaler SHALL count 0..DIV-1, DIV = CLK_HZ/TICK_HZ; tick is asserted for one cycle when the prescaler equals DIV-1.
REQ-013 Prescaler SHALL advance only in RUN, hold its value in PAUSED, and clear to 0 on load, on start from ARMED, and in IDLE/ARMED/EXPIRED.
REQ-014 FSM states: IDLE, ARMED, RUN, PAUSED, EXPIRED.
REQ-015 load in any state -> ARMED; remaining <= min(load_val, 100) on the next edge; load_val > 100 is clamped to 100.
REQ-016 start in ARMED -> RUN; start in PAUSED -> RUN; start in IDLE, RUN or EXPIRED is ignored.
REQ-017 pause in RUN -> PAUSED; pause in any other state is ignored.
REQ-018 Priority for same-cycle strobes SHALL be load > start > pause.
REQ-019 In RUN, each tick SHALL decrement remaining by 1.
REQ-020 Decrementing to 0 SHALL move the FSM to EXPIRED, with expired high for exactly the first cycle in EXPIRED.
REQ-021 start in ARMED with remaining == 0 -> EXPIRED on the next edge, with expired pulsed once and no RUN cycle.
REQ-022 remaining SHALL never wrap below 0 and SHALL hold at 0 in EXPIRED.
REQ-023 EXPIRED SHALL persist until load or reset.
REQ-024 A tick and a pause in the same cycle: the decrement SHALL take effect, then the FSM enters PAUSED.
REQ-025 Simultaneous pause and final tick (remaining == 1): the FSM SHALL enter EXPIRED, and the pause is dropped.
REQ-026 busy SHALL be derived combinationally from the state register.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE, with remaining = 0, expired = 0, busy = 0 and prescaler = 0.
REQ-028 reset SHALL override all strobes in the same cycle.
REQ-029 reset asserted mid-RUN or mid-PAUSED SHALL abort the countdown with no expired pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the constant MAX_TICKS = 100.
REQ-031 The prescaler SHALL be a separate sub-module, tick_gen (ports clk, reset, run, clear, tick), parameterised by CLK_HZ and TICK_HZ.
REQ-032 The top level SHALL contain only the FSM, the remaining register and the output logic.

Verification
REQ-033 With CLK_HZ = 100 and TICK_HZ = 10 (DIV = 10): load 5, then start -> remaining reaches 0 exactly 50 cycles after start, expired is high 1 cycle, busy drops in the same cycle.
REQ-034 Load 3, start, pause after 15 cycles, hold 40 cycles, start -> remaining is 2 throughout the pause; expiry occurs 15 cycles after resume.
REQ-035 Load 0, then start -> expired pulses on the next cycle and RUN is never entered.
REQ-036 Load 120 -> remaining = 100; load, start and pause asserted together in IDLE -> ARMED, and the start and pause are ignored.
REQ-037 Load 8, start, assert reset at remaining = 4 -> IDLE, remaining = 0, no expired pulse; a subsequent start is ignored.
REQ-038 Load 2, start, pause coincident with the final tick -> EXPIRED entered, expired pulsed once, and a later start is ignored.
